// File: rtl/fetch_queue_predictor.sv
// Decoupled fetch front end: requests words from memory control, predicts the next PC with a
// 2-bit-counter BHT and queues {inst, pc, predict, pred_pc} for the decoder.
module fetch_queue_predictor #(
    parameter int          QUEUE_DEPTH = 8,
    parameter int          BHT_BITS    = 6,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        mc_en,
    output logic [31:0] mc_addr,
    input  logic        mc_rdy,
    input  logic [31:0] mc_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_predict,
    output logic [31:0] out_pred_pc,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken
);

    localparam int AW    = $clog2(QUEUE_DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int BHT_N = 1 << BHT_BITS;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(QUEUE_DEPTH);
    localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ABORT = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        predict;
        logic [31:0] pred_pc;
    } entry_t;

    function automatic logic [31:0] imm_j(input logic [31:0] w);
        return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] w);
        return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    function automatic logic [1:0] sat_count(input logic [1:0] c, input logic up);
        logic [1:0] r;
        if (up) begin
            r = (c == 2'b11) ? 2'b11 : c + 2'b01;
        end else begin
            r = (c == 2'b00) ? 2'b00 : c - 2'b01;
        end
        return r;
    endfunction

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]         bht_q [BHT_N];
    entry_t             fifo_q [QUEUE_DEPTH];

    logic [PTR_W-1:0]   count_s;
    logic [PTR_W-1:0]   cnt_after_s;
    logic               push_s;
    logic               pop_s;
    logic               pred_taken_s;
    logic [31:0]        pred_pc_s;
    logic [BHT_BITS-1:0] fetch_idx_s;
    logic [BHT_BITS-1:0] upd_idx_s;
    entry_t             head_s;
    entry_t             new_entry_s;
    logic               unused_upd_bits_s;

    assign count_s     = wr_ptr_q - rd_ptr_q;
    assign out_valid   = (wr_ptr_q != rd_ptr_q);
    assign pop_s       = out_valid && out_ready && !flush;
    assign fetch_idx_s = pc_q[BHT_BITS+1:2];
    assign upd_idx_s   = upd_pc[BHT_BITS+1:2];
    assign unused_upd_bits_s = ^{upd_pc[31:BHT_BITS+2], upd_pc[1:0]};

    assign mc_en   = (state_q == ST_REQ);
    assign mc_addr = pc_q;

    assign head_s      = fifo_q[rd_ptr_q[AW-1:0]];
    assign out_inst    = out_valid ? head_s.inst    : 32'h0;
    assign out_pc      = out_valid ? head_s.pc      : 32'h0;
    assign out_predict = out_valid ? head_s.predict : 1'b0;
    assign out_pred_pc = out_valid ? head_s.pred_pc : 32'h0;

    // Static/BHT prediction on the word arriving from memory for the current fetch PC.
    always_comb begin
        pred_taken_s = 1'b0;
        pred_pc_s    = pc_q + 32'd4;
        case (mc_data[6:0])
            OP_JAL: begin
                pred_taken_s = 1'b1;
                pred_pc_s    = pc_q + imm_j(mc_data);
            end
            OP_BRANCH: begin
                pred_taken_s = bht_q[fetch_idx_s][1];
                if (pred_taken_s) begin
                    pred_pc_s = pc_q + imm_b(mc_data);
                end else begin
                    pred_pc_s = pc_q + 32'd4;
                end
            end
            default: begin
                pred_taken_s = 1'b0;
            end
        endcase
    end

    assign new_entry_s = '{inst: mc_data, pc: pc_q, predict: pred_taken_s, pred_pc: pred_pc_s};

    // Next-state logic for fetch FSM, PC and FIFO pointers; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        push_s      = 1'b0;
        cnt_after_s = count_s;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            pc_d     = flush_pc;
            state_d  = ST_ABORT;
        end else begin
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + ONE_P;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (count_s < DEPTH_P) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (mc_rdy) begin
                        push_s      = 1'b1;
                        wr_ptr_d    = wr_ptr_q + ONE_P;
                        pc_d        = pred_pc_s;
                        cnt_after_s = wr_ptr_d - rd_ptr_d;
                        // The slot for the next fetch is reserved before it is requested.
                        if (cnt_after_s < DEPTH_P) begin
                            state_d = ST_REQ;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_ABORT: begin
                    state_d = ST_REQ;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Control registers, frozen while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (rdy_in) begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are only visible through the valid-gated outputs.
    always_ff @(posedge clk_in) begin
        if (rdy_in && push_s) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= new_entry_s;
        end
    end

    // BHT training from committed branches, applied even in a flush cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (rdy_in && upd_en) begin
            bht_q[upd_idx_s] <= sat_count(bht_q[upd_idx_s], upd_taken);
        end
    end

endmodule
